// File: rtl/huff_pkg.sv
// Shared constants, FSM encoding and table-entry layout for the Huffman
// configuration loader.
package huff_pkg;

   localparam int W      = 8;
   localparam int MAX_CW = 4;

   // Per-width counters must hold the full capacity 2**MAX_CW.
   localparam int CNT_W  = MAX_CW + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FETCH,
      ST_CHECK,
      ST_PROG,
      ST_FIN,
      ST_ERR
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_WIDTH = 2'd1;
   localparam logic [1:0] ERR_CODE  = 2'd2;
   localparam logic [1:0] ERR_OVF   = 2'd3;

   localparam int D_LSB = 0;
   localparam int H_LSB = W;
   localparam int W_LSB = 2 * W;

   function automatic logic [CNT_W-1:0] capacity(input int c);
      return CNT_W'(1) << c;
   endfunction

endpackage

// File: rtl/huff_cfg_check.sv
// Validates one table entry and tracks how many codes of each width are
// already programmed.
module huff_cfg_check
   import huff_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] w,
   input  logic [W-1:0] h,
   output logic         pass,
   output logic [1:0]   code
);

   logic [MAX_CW:2] full;
   logic            sel_full;

   generate
      for (genvar gi = 2; gi <= MAX_CW; gi++) begin : g_cnt
         logic [CNT_W-1:0] count_reg;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               count_reg <= '0;
            end else if (inc && (w == W'(gi))) begin
               count_reg <= count_reg + 1'b1;
            end
         end

         assign full[gi] = (count_reg == capacity(gi));
      end
   endgenerate

   // Width check has priority, so the counter lookup only matters for legal widths.
   always_comb begin
      sel_full = 1'b0;
      code     = ERR_NONE;
      for (int i = 2; i <= MAX_CW; i++) begin
         if (w == W'(i)) begin
            sel_full = full[i];
         end
      end
      if ((w < W'(2)) || (w > W'(MAX_CW))) begin
         code = ERR_WIDTH;
      end else if ((h >> w) != '0) begin
         code = ERR_CODE;
      end else if (sel_full) begin
         code = ERR_OVF;
      end
      pass = (code == ERR_NONE);
   end

endmodule

// File: rtl/huff_cfg_loader.sv
// Sequencer that clears the Huffman datapath table, then fetches, validates
// and writes each entry from table memory before enabling the datapath.
module huff_cfg_loader
   import huff_pkg::*;
#(
   parameter int AW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [AW:0]    n_entries,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [1:0]     err_code,
   output logic           mem_rd,
   output logic [AW-1:0]  mem_addr,
   input  logic [3*W-1:0] mem_rdata,
   output logic [W-1:0]   d_conf,
   output logic [W-1:0]   h_conf,
   output logic [W-1:0]   w_conf,
   output logic           en_conf,
   output logic           new_conf,
   output logic           cfg_valid
);

   localparam int          N_MAX   = 2**AW;
   localparam logic [AW:0] N_MAX_V = (AW+1)'(N_MAX);

   state_t          state_reg, state_next;
   logic [AW:0]     n_reg;
   logic [AW-1:0]   index_reg;
   logic            err_reg;
   logic [1:0]      err_code_reg;
   logic            cfg_valid_reg;
   logic [W-1:0]    d_conf_reg, h_conf_reg, w_conf_reg;

   logic [W-1:0]    rd_d, rd_h, rd_w;
   logic            accept, last_entry, chk_pass;
   logic [1:0]      chk_code;

   assign rd_d = mem_rdata[D_LSB +: W];
   assign rd_h = mem_rdata[H_LSB +: W];
   assign rd_w = mem_rdata[W_LSB +: W];

   assign accept     = (state_reg == ST_IDLE) && start;
   assign last_entry = ({1'b0, index_reg} == (n_reg - 1'b1));

   huff_cfg_check u_check (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .inc  ((state_reg == ST_CHECK) && chk_pass),
      .w    (rd_w),
      .h    (rd_h),
      .pass (chk_pass),
      .code (chk_code)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = (n_entries > N_MAX_V) ? ST_ERR : ST_CLEAR;
            end
         end
         ST_CLEAR: state_next = (n_reg == '0) ? ST_FIN : ST_FETCH;
         ST_FETCH: state_next = ST_CHECK;
         ST_CHECK: state_next = chk_pass ? ST_PROG : ST_ERR;
         ST_PROG:  state_next = last_entry ? ST_FIN : ST_FETCH;
         ST_FIN:   state_next = ST_IDLE;
         ST_ERR:   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // cfg_valid and err are set on the transition so they are already
   // visible alongside the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_reg         <= '0;
         index_reg     <= '0;
         err_reg       <= 1'b0;
         err_code_reg  <= ERR_NONE;
         cfg_valid_reg <= 1'b0;
         d_conf_reg    <= '0;
         h_conf_reg    <= '0;
         w_conf_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  n_reg         <= n_entries;
                  index_reg     <= '0;
                  cfg_valid_reg <= 1'b0;
                  if (n_entries > N_MAX_V) begin
                     err_reg      <= 1'b1;
                     err_code_reg <= ERR_OVF;
                  end else begin
                     err_reg      <= 1'b0;
                     err_code_reg <= ERR_NONE;
                  end
               end
            end
            ST_CLEAR: begin
               if (n_reg == '0) begin
                  cfg_valid_reg <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (chk_pass) begin
                  d_conf_reg <= rd_d;
                  h_conf_reg <= rd_h;
                  w_conf_reg <= rd_w;
               end else begin
                  err_reg      <= 1'b1;
                  err_code_reg <= chk_code;
               end
            end
            ST_PROG: begin
               index_reg <= index_reg + 1'b1;
               if (last_entry) begin
                  cfg_valid_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_FIN) || (state_reg == ST_ERR);
   assign mem_rd    = (state_reg == ST_FETCH);
   assign en_conf   = (state_reg == ST_PROG);
   assign new_conf  = (state_reg == ST_CLEAR);
   assign mem_addr  = index_reg;
   assign err       = err_reg;
   assign err_code  = err_code_reg;
   assign cfg_valid = cfg_valid_reg;
   assign d_conf    = d_conf_reg;
   assign h_conf    = h_conf_reg;
   assign w_conf    = w_conf_reg;

endmodule

// File: tb/tb_huff_cfg_loader.sv
// Bench for huff_cfg_loader: directed vector table, reset/busy-start corner
// sequences and randomized loads against a per-entry reference model.
module tb_huff_cfg_loader;
   import huff_pkg::*;

   localparam int AW   = 6;
   localparam int NMAX = 64;

   logic           clk = 1'b0;
   logic           rst, start;
   logic [AW:0]    n_entries;
   logic           busy, done, err, mem_rd, en_conf, new_conf, cfg_valid;
   logic [1:0]     err_code;
   logic [AW-1:0]  mem_addr;
   logic [3*W-1:0] mem_rdata = '0;
   logic [W-1:0]   d_conf, h_conf, w_conf;

   logic [3*W-1:0] tbl [0:NMAX-1];

   huff_cfg_loader #(.AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .n_entries(n_entries),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .d_conf(d_conf), .h_conf(h_conf), .w_conf(w_conf),
      .en_conf(en_conf), .new_conf(new_conf), .cfg_valid(cfg_valid)
   );

   always #5 clk = ~clk;

   // Table RAM: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= tbl[mem_addr];
   end

   typedef struct {
      int c;
      logic [W-1:0] d, h, w;
   } wr_t;

   typedef struct {
      int n;
      logic [4:0][3*W-1:0] e;
      int wr, dn, er, cd;
   } vec_t;

   vec_t vecs [10];
   wr_t  got_wr [$];
   int   got_nc [$];
   int   got_rd [$];
   int   got_done, got_cfg1, got_err1;
   int   post_err, post_code, post_cfg, post_busy, post_d;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   ew, ed, ee, ec, strobes;

   function automatic logic [3*W-1:0] ent(input logic [W-1:0] d, h, w);
      return {w, h, d};
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
   endtask

   task automatic set_vec(input int i, input int n,
                          input logic [3*W-1:0] e0, e1, e2, e3, e4,
                          input int wr, dn, er, cd);
      vecs[i].n = n;
      vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2;
      vecs[i].e[3] = e3; vecs[i].e[4] = e4;
      vecs[i].wr = wr; vecs[i].dn = dn; vecs[i].er = er; vecs[i].cd = cd;
   endtask

   // Reference: walk entries in order, applying the validation rules with a
   // simple per-width tally; first failure ends the load.
   task automatic model(input int n, output int m_wr, m_dn, m_er, m_cd);
      int cnt [256];
      int w, h, code;
      for (int i = 0; i < 256; i++) cnt[i] = 0;
      if (n > NMAX) begin
         m_wr = 0; m_dn = 1; m_er = 1; m_cd = 3;
         return;
      end
      for (int k = 0; k < n; k++) begin
         w = int'(tbl[k][3*W-1:2*W]);
         h = int'(tbl[k][2*W-1:W]);
         code = 0;
         if (w < 2 || w > MAX_CW) code = 1;
         else if ((h >> w) != 0) code = 2;
         else if (cnt[w] == (1 << w)) code = 3;
         if (code != 0) begin
            m_wr = k; m_dn = 4 + 3*k; m_er = 1; m_cd = code;
            return;
         end
         cnt[w]++;
      end
      m_wr = n; m_dn = 2 + 3*n; m_er = 0; m_cd = 0;
   endtask

   // Called at a negedge with the DUT idle; start is applied in relative cycle 0.
   task automatic run_load(input int n, input bit noise);
      int rel;
      got_wr.delete(); got_nc.delete(); got_rd.delete();
      got_done = -1;
      n_entries = n[AW:0];
      start = 1'b1;
      rel = 0;
      while (got_done < 0 && rel < 400) begin
         @(negedge clk);
         rel++;
         if (rel == 1) begin
            got_cfg1 = int'(cfg_valid);
            got_err1 = int'(err);
         end
         if (new_conf) got_nc.push_back(rel);
         if (mem_rd)   got_rd.push_back(int'(mem_addr));
         if (en_conf)  got_wr.push_back('{rel, d_conf, h_conf, w_conf});
         if (done)     got_done = rel;
         if (noise && busy) begin
            start     = 1'($urandom_range(0, 1));
            n_entries = (AW+1)'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      start     = 1'b0;
      post_err  = int'(err);
      post_code = int'(err_code);
      post_cfg  = int'(cfg_valid);
      post_busy = int'(busy);
      post_d    = int'(d_conf);
   endtask

   task automatic check_load(input string nm, input int n,
                             input int x_wr, x_dn, x_er, x_cd);
      int x_nc, x_rd;
      x_nc = (n <= NMAX) ? 1 : 0;
      x_rd = (n <= NMAX) ? x_wr + x_er : 0;
      chk({nm, "_newconf_cnt"}, got_nc.size(), x_nc);
      if (x_nc == 1 && got_nc.size() > 0) chk({nm, "_newconf_cyc"}, got_nc[0], 1);
      chk({nm, "_cfgvalid_drop"}, got_cfg1, 0);
      chk({nm, "_err_at1"}, got_err1, (n > NMAX) ? 1 : 0);
      chk({nm, "_rd_cnt"}, got_rd.size(), x_rd);
      for (int k = 0; k < got_rd.size() && k < x_rd; k++)
         chk($sformatf("%s_rd%0d_addr", nm, k), got_rd[k], k);
      chk({nm, "_wr_cnt"}, got_wr.size(), x_wr);
      for (int k = 0; k < got_wr.size() && k < x_wr; k++) begin
         chk($sformatf("%s_wr%0d_cyc", nm, k), got_wr[k].c, 4 + 3*k);
         chk($sformatf("%s_wr%0d_d", nm, k), int'(got_wr[k].d), int'(tbl[k][W-1:0]));
         chk($sformatf("%s_wr%0d_h", nm, k), int'(got_wr[k].h), int'(tbl[k][2*W-1:W]));
         chk($sformatf("%s_wr%0d_w", nm, k), int'(got_wr[k].w), int'(tbl[k][3*W-1:2*W]));
      end
      chk({nm, "_done_cyc"}, got_done, x_dn);
      chk({nm, "_err"}, post_err, x_er);
      chk({nm, "_err_code"}, post_code, x_cd);
      chk({nm, "_cfg_valid"}, post_cfg, (x_er == 0) ? 1 : 0);
      chk({nm, "_busy_after"}, post_busy, 0);
      if (x_wr > 0) chk({nm, "_conf_hold"}, post_d, int'(tbl[x_wr-1][W-1:0]));
      $display("load %s n=%0d writes=%0d done@%0d err=%0d code=%0d",
               nm, n, got_wr.size(), got_done, post_err, post_code);
   endtask

   initial begin
      for (int k = 0; k < NMAX; k++) tbl[k] = '0;
      set_vec(0, 3, ent(8'h41,0,2), ent(8'h42,1,2), ent(8'h43,4,3), 0, 0, 3, 11, 0, 0);
      set_vec(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      set_vec(2, 2, ent(8'h11,0,2), ent(8'h55,0,5), 0, 0, 0, 1, 7, 1, 1);
      set_vec(3, 1, ent(8'h10,5,2), 0, 0, 0, 0, 0, 4, 1, 2);
      set_vec(4, 5, ent(8'h20,0,2), ent(8'h21,1,2), ent(8'h22,2,2), ent(8'h23,3,2),
              ent(8'h24,0,2), 4, 16, 1, 3);
      set_vec(5, 65, 0, 0, 0, 0, 0, 0, 1, 1, 3);
      set_vec(6, 1, ent(8'h99,7,3), 0, 0, 0, 0, 1, 5, 0, 0);
      set_vec(7, 2, ent(8'hAA,15,4), ent(8'hBB,8'h10,4), 0, 0, 0, 1, 7, 1, 2);
      set_vec(8, 1, ent(8'h01,0,1), 0, 0, 0, 0, 0, 4, 1, 1);
      set_vec(9, 1, ent(8'h02,0,0), 0, 0, 0, 0, 0, 4, 1, 1);

      rst = 1'b1; start = 1'b0; n_entries = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          int'({busy, done, err, err_code, mem_rd, mem_addr, d_conf, h_conf, w_conf,
                en_conf, new_conf, cfg_valid}), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 5; k++) tbl[k] = vecs[i].e[k];
         run_load(vecs[i].n, i == 0);
         check_load($sformatf("vec%0d", i), vecs[i].n, vecs[i].wr, vecs[i].dn,
                    vecs[i].er, vecs[i].cd);
      end

      // Reset in the middle of a 3-entry load.
      for (int k = 0; k < 5; k++) tbl[k] = vecs[0].e[k];
      n_entries = 7'd3;
      start = 1'b1;
      for (int rel = 1; rel <= 5; rel++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_outputs",
          int'({busy, done, err, err_code, mem_rd, mem_addr, d_conf, h_conf, w_conf,
                en_conf, new_conf, cfg_valid}), 0);
      rst = 1'b0;
      strobes = 0;
      repeat (20) begin
         @(negedge clk);
         if (en_conf || mem_rd || new_conf || done || busy) strobes++;
      end
      chk("midreset_quiet", strobes, 0);
      $display("load midreset strobes_after=%0d", strobes);

      // N_MAX entries is accepted (clear issued); total capacity forces code 3.
      for (int k = 0; k < NMAX; k++) tbl[k] = ent(8'(k), 8'(k % 4), 2);
      model(NMAX, ew, ed, ee, ec);
      run_load(NMAX, 1'b0);
      check_load("nmax", NMAX, ew, ed, ee, ec);

      for (int t = 0; t < 30; t++) begin
         int r, n, w, h;
         for (int k = 0; k < NMAX; k++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      w = int'($urandom_range(0, 1));
            else if (r == 1) w = int'($urandom_range(5, 255));
            else             w = int'($urandom_range(2, MAX_CW));
            if (w >= 2 && w <= MAX_CW && $urandom_range(0, 9) != 0)
               h = int'($urandom_range(0, (1 << w) - 1));
            else
               h = int'($urandom_range(0, 255));
            tbl[k] = ent(8'($urandom), 8'(h), 8'(w));
         end
         r = int'($urandom_range(0, 9));
         if (r == 0)      n = NMAX;
         else if (r == 1) n = NMAX + 1 + int'($urandom_range(0, 62));
         else             n = int'($urandom_range(0, 12));
         model(n, ew, ed, ee, ec);
         run_load(n, 1'($urandom_range(0, 1)));
         check_load($sformatf("rnd%0d", t), n, ew, ed, ee, ec);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
